// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences privilege-transfer events (exceptions, interrupts, MRET/SRET).
//
// One event is captured while idle. The sequencer then drains the pipeline,
// commits the CSR update with a single pulse, and redirects fetch.
//
// Ports:
//   clk, rstn            core clock, synchronous active-low reset
//   exc_*                synchronous exception request, cause, tval and faulting PC
//   irq_pend             pending-and-enabled interrupt bits (mip & mie)
//   mret_req, sret_req   xRET retiring
//   prv_cur, mstatus_*   current privilege and status fields used for
//                        enable checks and return privilege
//   medeleg, mideleg     delegation masks
//   mtvec/stvec          trap vectors
//   mepc/sepc            return PCs
//   flush_req/flush_ack  pipeline drain handshake
//   busy                 sequencer active; upstream stalls and holds requests
//   trap_wr + trap_*     one-cycle CSR trap commit and its values
//   ret_wr, ret_is_m     one-cycle xRET status update
//   prv_nxt              new privilege, valid with trap_wr or ret_wr
//   redirect_valid/pc    one-cycle PC load
module trap_ctrl #(
  parameter int XLEN  = 32,
  parameter int IRQ_W = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              exc_req,
  input  logic [XLEN-1:0]   exc_cause,
  input  logic [XLEN-1:0]   exc_val,
  input  logic [XLEN-1:0]   exc_pc,
  input  logic [IRQ_W-1:0]  irq_pend,
  input  logic              mret_req,
  input  logic              sret_req,
  input  logic [1:0]        prv_cur,
  input  logic              mstatus_mie,
  input  logic              mstatus_sie,
  input  logic [1:0]        mstatus_mpp,
  input  logic              mstatus_spp,
  input  logic [15:0]       medeleg,
  input  logic [IRQ_W-1:0]  mideleg,
  input  logic [XLEN-1:0]   mtvec,
  input  logic [XLEN-1:0]   stvec,
  input  logic [XLEN-1:0]   mepc,
  input  logic [XLEN-1:0]   sepc,
  output logic              flush_req,
  input  logic              flush_ack,
  output logic              busy,
  output logic              trap_wr,
  output logic [1:0]        trap_prv,
  output logic [XLEN-1:0]   trap_epc,
  output logic [XLEN-1:0]   trap_cause,
  output logic [XLEN-1:0]   trap_tval,
  output logic              ret_wr,
  output logic              ret_is_m,
  output logic [1:0]        prv_nxt,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc
);

  typedef enum logic [1:0] {IDLE, FLUSH, COMMIT, REDIRECT} state_t;

  // Interrupt number held in each priority slot, slot 0 is the most urgent.
  function automatic int irq_idx(input int slot);
    case (slot)
      0:       return 11;
      1:       return 3;
      2:       return 7;
      3:       return 9;
      4:       return 1;
      default: return 5;
    endcase
  endfunction

  state_t state_reg, state_next;

  logic             is_trap_reg, is_irq_reg, ret_is_m_reg;
  logic [1:0]       trap_prv_reg, prv_nxt_reg;
  logic [XLEN-1:0]  trap_epc_reg, trap_cause_reg, trap_tval_reg, redirect_pc_reg;

  // Per-slot: pending, enabled under its resolved target, and that target.
  logic [5:0] irq_take;
  logic [5:0] irq_to_s;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_irq
      localparam int IDX = irq_idx(gi);
      logic to_s;
      logic en;
      always_comb begin
        to_s = mideleg[IDX] && (prv_cur <= 2'd1);
        if (to_s)
          en = (prv_cur == 2'd0) || ((prv_cur == 2'd1) && mstatus_sie);
        else
          en = (prv_cur != 2'd3) || mstatus_mie;
      end
      assign irq_take[gi] = irq_pend[IDX] && en;
      assign irq_to_s[gi] = to_s;
    end
  endgenerate

  // Non-standard interrupt lines are deliberately ignored.
  logic unused_bits;
  assign unused_bits = &{1'b0, irq_pend, mideleg};

  logic       irq_any, irq_sel_s;
  logic [3:0] irq_sel;

  always_comb begin
    irq_any   = |irq_take;
    irq_sel   = 4'd0;
    irq_sel_s = 1'b0;
    // Walk from lowest to highest priority so the most urgent slot wins.
    for (int k = 5; k >= 0; k--) begin
      if (irq_take[k]) begin
        irq_sel   = 4'(irq_idx(k));
        irq_sel_s = irq_to_s[k];
      end
    end
  end

  logic exc_to_s;
  assign exc_to_s = medeleg[exc_cause[3:0]] && (prv_cur != 2'd3);

  logic capture;
  assign capture = (state_reg == IDLE) && (exc_req || irq_any || mret_req || sret_req);

  // Redirect target, evaluated while in COMMIT.
  logic [XLEN-1:0] tvec_sel, tvec_base, vec_off, pc_next;

  always_comb begin
    tvec_sel  = (trap_prv_reg == 2'd1) ? stvec : mtvec;
    tvec_base = {tvec_sel[XLEN-1:2], 2'b00};
    vec_off   = {{(XLEN-6){1'b0}}, trap_cause_reg[3:0], 2'b00};
    if (is_trap_reg) begin
      if ((tvec_sel[1:0] == 2'b01) && is_irq_reg)
        pc_next = tvec_base + vec_off;
      else
        pc_next = tvec_base;
    end else begin
      pc_next = ret_is_m_reg ? mepc : sepc;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (capture) state_next = FLUSH;
      FLUSH:    if (flush_ack) state_next = COMMIT;
      COMMIT:   state_next = REDIRECT;
      REDIRECT: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg       <= IDLE;
      is_trap_reg     <= 1'b0;
      is_irq_reg      <= 1'b0;
      ret_is_m_reg    <= 1'b0;
      trap_prv_reg    <= 2'd0;
      prv_nxt_reg     <= 2'd0;
      trap_epc_reg    <= '0;
      trap_cause_reg  <= '0;
      trap_tval_reg   <= '0;
      redirect_pc_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        if (exc_req) begin
          is_trap_reg    <= 1'b1;
          is_irq_reg     <= 1'b0;
          trap_prv_reg   <= exc_to_s ? 2'd1 : 2'd3;
          prv_nxt_reg    <= exc_to_s ? 2'd1 : 2'd3;
          trap_cause_reg <= exc_cause;
          trap_tval_reg  <= exc_val;
          trap_epc_reg   <= exc_pc;
        end else if (irq_any) begin
          is_trap_reg    <= 1'b1;
          is_irq_reg     <= 1'b1;
          trap_prv_reg   <= irq_sel_s ? 2'd1 : 2'd3;
          prv_nxt_reg    <= irq_sel_s ? 2'd1 : 2'd3;
          trap_cause_reg <= {1'b1, {(XLEN-5){1'b0}}, irq_sel};
          trap_tval_reg  <= '0;
          trap_epc_reg   <= exc_pc;
        end else begin
          // xRET: trap_* registers are left alone, only return data latched.
          is_trap_reg  <= 1'b0;
          is_irq_reg   <= 1'b0;
          ret_is_m_reg <= mret_req;
          prv_nxt_reg  <= mret_req ? mstatus_mpp : {1'b0, mstatus_spp};
        end
      end
      if (state_reg == COMMIT)
        redirect_pc_reg <= pc_next;
    end
  end

  assign busy           = (state_reg != IDLE);
  assign flush_req      = (state_reg == FLUSH);
  assign trap_wr        = (state_reg == COMMIT) && is_trap_reg;
  assign ret_wr         = (state_reg == COMMIT) && !is_trap_reg;
  assign redirect_valid = (state_reg == REDIRECT);
  assign trap_prv       = trap_prv_reg;
  assign trap_epc       = trap_epc_reg;
  assign trap_cause     = trap_cause_reg;
  assign trap_tval      = trap_tval_reg;
  assign ret_is_m       = ret_is_m_reg;
  assign prv_nxt        = prv_nxt_reg;
  assign redirect_pc    = redirect_pc_reg;

endmodule
